row_readout_arbiter: RTL and testbench

Collects per-row ADC words (BITS_ADC data + 1 flag bit) from the ROW_NUM row blocks and grants one row at a time, round-robin. Each captured word is packed into a LEN_SPI-bit packet tagged with a sync nibble, row index and sequence number. Packets are buffered in an internal FIFO and pushed into the SPI slave transmit path (tx_input/push_tx). Sits in the clk_50M domain between the row-block parallel outputs and spi_std_slave.

---
 rtl/row_readout_arbiter.sv | 155 +++++++++++++++
 tb/tb_row_readout_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_readout_arbiter.sv
// row_readout_arbiter
//   Round-robin arbiter that collects ADC words from the row blocks, packs each
//   capture into a 32-bit packet {4'hA sync, row index, seq[10:0], word} and
//   feeds the packets through a small FIFO into the SPI slave transmit path.
//
// Ports
//   clk_50M     system clock
//   rst         synchronous reset, active high
//   enable      high: arbitration permitted (FIFO drains regardless)
//   row_req     per-row word-ready request, held until acked
//   p_data      row words, row x at [x*(BITS_ADC+1) +: BITS_ADC+1]
//   row_ack     one-hot, one-cycle capture acknowledge
//   tx_free     SPI transmit buffer can accept a packet
//   tx_input    packet to SPI slave, held between pushes
//   push_tx     one-cycle load strobe to SPI slave
//   fifo_level  current FIFO occupancy
//   busy        FSM not idle or FIFO non-empty
module row_readout_arbiter #(
  parameter int ROW_NUM    = 8,
  parameter int BITS_ADC   = 12,
  parameter int LEN_SPI    = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk_50M,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [ROW_NUM-1:0]                row_req,
  input  logic [ROW_NUM*(BITS_ADC+1)-1:0]   p_data,
  output logic [ROW_NUM-1:0]                row_ack,
  input  logic                              tx_free,
  output logic [LEN_SPI-1:0]                tx_input,
  output logic                              push_tx,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              busy
);

  localparam int WORD_W = BITS_ADC + 1;
  localparam int ROW_W  = $clog2(ROW_NUM);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ARB, ACK} state_t;

  state_t               state, state_next;
  logic [ROW_W-1:0]     rr, grant, grant_next;
  logic                 found;
  logic                 grant_load, ack_en;
  logic [10:0]          seq;
  logic [WORD_W-1:0]    word;
  logic [31:0]          pkt;

  logic [LEN_SPI-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     count;
  logic                 wr_en, pop, fifo_full;
  logic [LEN_SPI-1:0]   head;

  // Round-robin search starting one past the last granted row.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    found      = 1'b0;
    grant_next = rr;
    for (int i = 1; i <= ROW_NUM; i++) begin
      if (!found && row_req[(int'(rr) + i) % ROW_NUM]) begin
        found      = 1'b1;
        grant_next = ROW_W'((int'(rr) + i) % ROW_NUM);
      end
    end
  end

  assign fifo_full = (count == LVL_W'(FIFO_DEPTH));

  always_ff @(posedge clk_50M) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_load = 1'b0;
    ack_en     = 1'b0;
    unique case (state)
      IDLE: if (enable) state_next = ARB;
      ARB: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (found && !fifo_full) begin
          state_next = ACK;
          grant_load = 1'b1;
        end
      end
      ACK: begin
        ack_en     = 1'b1;
        state_next = enable ? ARB : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gating with rst keeps the ack quiet in a cycle whose capture is discarded.
  assign row_ack = (ack_en && !rst) ? (ROW_NUM'(1) << grant) : '0;
  assign wr_en   = ack_en;

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      rr    <= ROW_W'(ROW_NUM - 1);
      grant <= '0;
      seq   <= '0;
    end else begin
      if (grant_load) grant <= grant_next;
      if (wr_en) begin
        rr  <= grant;
        seq <= seq + 11'd1;
      end
    end
  end

  assign word = p_data[int'(grant)*WORD_W +: WORD_W];
  assign pkt  = {4'hA, 4'(grant), seq, 13'(word)};

  // When the FIFO is empty the packet being captured is forwarded directly,
  // so a lone capture reaches the SPI slave on the very next cycle.
  assign head = (count == '0) ? LEN_SPI'(pkt) : mem[rd_ptr];
  assign pop  = ((count != '0) || wr_en) && tx_free && !push_tx;

  always_ff @(posedge clk_50M) begin
    // NOTE: the storage array is not reset; occupancy is tracked by count/pointers, which are.
    if (wr_en) mem[wr_ptr] <= LEN_SPI'(pkt);
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      push_tx  <= 1'b0;
      tx_input <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      push_tx <= pop;
      if (pop) tx_input <= head;
    end
  end

  assign fifo_level = count;
  assign busy       = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_row_readout_arbiter.sv
// Testbench for row_readout_arbiter: table-driven first transaction plus
// directed sequences for round robin, FIFO full, seq wrap, mid-run reset and
// enable drop. A scoreboard queue holds expected packets in ack order.
module tb_row_readout_arbiter;

  localparam int ROW_NUM = 8;
  localparam int WORD_W  = 13;

  logic         clk_50M = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [7:0]   row_req = '0;
  logic [103:0] p_data = '0;
  logic [7:0]   row_ack;
  logic         tx_free = 1'b0;
  logic [31:0]  tx_input;
  logic         push_tx;
  logic [3:0]   fifo_level;
  logic         busy;

  always #5 clk_50M = ~clk_50M;

  row_readout_arbiter #(
    .ROW_NUM(8), .BITS_ADC(12), .LEN_SPI(32), .FIFO_DEPTH(8)
  ) dut (
    .clk_50M(clk_50M), .rst(rst), .enable(enable), .row_req(row_req),
    .p_data(p_data), .row_ack(row_ack), .tx_free(tx_free),
    .tx_input(tx_input), .push_tx(push_tx), .fifo_level(fifo_level),
    .busy(busy)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb_q[$];
  int          sb_seq = 0;
  logic        prev_push = 1'b0;
  int          cyc = 0;
  int          ack_cnt = 0;
  int          push_cnt = 0;
  logic [7:0]  last_ack = '0;
  logic [12:0] words [8];

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  req;
    logic        tf;
    logic [7:0]  ack;
    logic        push;
    logic [3:0]  lvl;
    logic        busy;
    logic [31:0] tx;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pkt_of(input int row, input int seq);
    return {4'hA, 4'(row), 11'(seq), words[row]};
  endfunction

  task automatic load_words();
    for (int i = 0; i < ROW_NUM; i++) p_data[i*WORD_W +: WORD_W] = words[i];
  endtask

  // One clock: sample after the edge, record acks, check pushes.
  task automatic cycle();
    int r;
    @(posedge clk_50M);
    #1;
    cyc++;
    last_ack = row_ack;
    if (row_ack != '0) begin
      check("ack_onehot", 32'($onehot(row_ack)), 32'd1);
      r = 0;
      for (int i = ROW_NUM - 1; i >= 0; i--) if (row_ack[i]) r = i;
      sb_q.push_back(pkt_of(r, sb_seq));
      sb_seq++;
      ack_cnt++;
    end
    if (push_tx) begin
      check("push_gap", 32'(prev_push), 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL push_unexpected: got %h expected no push", tx_input);
      end else begin
        check("push_pkt", tx_input, sb_q.pop_front());
      end
      push_cnt++;
    end
    prev_push = push_tx;
  endtask

  task automatic clear_sb();
    sb_q.delete();
    sb_seq = 0;
    prev_push = 1'b0;
    ack_cnt = 0;
    push_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    row_req = '0;
    tx_free = 1'b0;
    cycle();
    rst = 1'b0;
    clear_sb();
  endtask

  initial begin
    int exp_row;
    int prev_ack_cyc;
    int n;
    logic [7:0] reraise;
    logic ok;

    for (int i = 0; i < ROW_NUM; i++) words[i] = 13'h100 + 13'(i);
    words[2] = 13'h1ABC;
    load_words();

    // ---- Test 1: first transaction, table driven ----
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 8'h04, 1'b1, 8'h00, 1'b0, 4'd0, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 8'h04, 1'b1, 8'h04, 1'b0, 4'd0, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 4'd0, 1'b1, 32'hA2001ABC};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 4'd0, 1'b1, 32'hA2001ABC};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 4'd0, 1'b0, 32'hA2001ABC};
    for (int v = 0; v < 6; v++) begin
      rst = vecs[v].rst;
      enable = vecs[v].en;
      row_req = vecs[v].req;
      tx_free = vecs[v].tf;
      cycle();
      if (v == 0) clear_sb();
      check($sformatf("t1_ack[%0d]", v), 32'(row_ack), 32'(vecs[v].ack));
      check($sformatf("t1_push[%0d]", v), 32'(push_tx), 32'(vecs[v].push));
      check($sformatf("t1_level[%0d]", v), 32'(fifo_level), 32'(vecs[v].lvl));
      check($sformatf("t1_busy[%0d]", v), 32'(busy), 32'(vecs[v].busy));
      check($sformatf("t1_tx[%0d]", v), tx_input, vecs[v].tx);
    end
    words[2] = 13'h102;
    load_words();

    // ---- Test 2: round robin across all rows, drop/re-raise after ack ----
    do_reset();
    enable = 1'b1;
    tx_free = 1'b1;
    row_req = 8'hFF;
    exp_row = 0;
    prev_ack_cyc = -1;
    reraise = '0;
    n = 0;
    while (n < 60 && (ack_cnt < 9 || push_cnt < 9)) begin
      cycle();
      n++;
      row_req = row_req | reraise;
      reraise = '0;
      if (last_ack != '0) begin
        check("rr_order", 32'(last_ack), 32'(1) << exp_row);
        exp_row = (exp_row + 1) % ROW_NUM;
        if (prev_ack_cyc >= 0) check("rr_spacing", 32'(cyc - prev_ack_cyc), 32'd2);
        prev_ack_cyc = cyc;
        row_req = row_req & ~last_ack;
        reraise = last_ack;
      end
    end
    check("rr_ack_count", 32'(ack_cnt), 32'd9);
    check("rr_push_count", 32'(push_cnt), 32'd9);

    // ---- Test 3: FIFO fills with tx_free low, then drains ----
    do_reset();
    enable = 1'b1;
    tx_free = 1'b0;
    row_req = 8'h0F;
    exp_row = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (last_ack != '0) begin
        check("full_order", 32'(last_ack), 32'(1) << exp_row);
        exp_row = (exp_row + 1) % 4;
      end
    end
    check("full_ack_count", 32'(ack_cnt), 32'd8);
    check("full_level", 32'(fifo_level), 32'd8);
    check("full_no_push", 32'(push_cnt), 32'd0);
    tx_free = 1'b1;
    n = 0;
    while (n < 80 && push_cnt < 8) begin
      cycle();
      n++;
      if (last_ack != '0) begin
        check("drain_order", 32'(last_ack), 32'(1) << exp_row);
        exp_row = (exp_row + 1) % 4;
      end
    end
    check("drain_push_count", 32'(push_cnt >= 8), 32'd1);
    check("drain_arb_resumed", 32'(ack_cnt > 8), 32'd1);
    row_req = '0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (fifo_level == 0 && sb_q.size() == 0 && !push_tx) break;
    end
    check("drain_level_zero", 32'(fifo_level), 32'd0);
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);

    // ---- Test 4: sequence number wraps 2047 -> 0 ----
    do_reset();
    enable = 1'b1;
    tx_free = 1'b1;
    row_req = 8'h02;
    reraise = '0;
    n = 0;
    while (n < 5000 && push_cnt < 2049) begin
      cycle();
      n++;
      row_req = row_req | reraise;
      reraise = '0;
      if (last_ack != '0) begin
        row_req = row_req & ~last_ack;
        reraise = last_ack;
      end
      if (push_tx && push_cnt == 2048) check("seq_2047", 32'(tx_input[23:13]), 32'd2047);
      if (push_tx && push_cnt == 2049) check("seq_wrap", 32'(tx_input[23:13]), 32'd0);
    end
    check("wrap_push_count", 32'(push_cnt), 32'd2049);

    // ---- Test 5: reset while in ACK with 5 packets buffered ----
    do_reset();
    enable = 1'b1;
    tx_free = 1'b0;
    row_req = 8'hF0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (row_ack != '0 && fifo_level == 4'd5) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_setup_reached", 32'(ok), 32'd1);
    rst = 1'b1;
    cycle();
    check("rst_ack", 32'(row_ack), 32'd0);
    check("rst_push", 32'(push_tx), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx", tx_input, 32'd0);
    clear_sb();
    rst = 1'b0;
    enable = 1'b1;
    tx_free = 1'b1;
    row_req = 8'h28;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (last_ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
    check("post_rst_grant", 32'(last_ack), 32'h08);
    row_req = '0;
    cycle();
    check("post_rst_push", 32'(push_tx), 32'd1);
    check("post_rst_pkt", tx_input, 32'hA3000103);

    // ---- Test 6: enable dropped during ACK ----
    do_reset();
    enable = 1'b1;
    tx_free = 1'b0;
    row_req = 8'h07;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (last_ack != '0) break;
    end
    check("en_first_ack", 32'(last_ack), 32'h01);
    enable = 1'b0;
    cycle();
    check("en_ack_done", 32'(row_ack), 32'd0);
    check("en_level_held", 32'(fifo_level), 32'd1);
    check("en_busy_fifo", 32'(busy), 32'd1);
    tx_free = 1'b1;
    for (int k = 0; k < 10; k++) cycle();
    check("en_no_more_acks", 32'(ack_cnt), 32'd1);
    check("en_push_count", 32'(push_cnt), 32'd1);
    check("en_level_zero", 32'(fifo_level), 32'd0);
    check("en_busy_zero", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
